screen_select: RTL and testbench

Frame-synchronous screen multiplexer placed after the parallel draw stages: menu, game, player-1-won and player-2-won. It tracks the game phase in a small state machine and forwards exactly one source's timing and rgb to the VGA output stage. Screen changes happen only at the start of vertical blanking, so no frame tears. The won screens time out back to the menu after a fixed number of frames.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_if.sv | 13 +
 rtl/frame_tick.sv | 26 ++
 rtl/screen_select.sv | 166 ++++++++++++++++
 tb/tb_screen_select.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA stream types and the screen-phase enum used by the screen selector.
package vga_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned FRAME_W = 16;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    GAME   = 2'd1,
    P1_WON = 2'd2,
    P2_WON = 2'd3
  } screen_t;

  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount;
    logic             vsync;
    logic             hsync;
    logic             vblnk;
    logic             hblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

  function automatic logic is_won(input screen_t s);
    return (s == P1_WON) || (s == P2_WON);
  endfunction

endpackage

// File: rtl/vga_if.sv
// One VGA pixel stream: timing counters, sync/blank flags and rgb.
interface vga_if;
  logic [vga_pkg::CNT_W-1:0] vcount;
  logic [vga_pkg::CNT_W-1:0] hcount;
  logic                      vsync;
  logic                      hsync;
  logic                      vblnk;
  logic                      hblnk;
  logic [vga_pkg::RGB_W-1:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/frame_tick.sv
// Single-cycle pulse on the rising edge of vblnk, marking the start of a frame's blanking.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;
  logic vblnk_d;

  always_comb begin
    vblnk_d = vblnk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk_d;
    end
  end

  assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/screen_select.sv
// Frame-synchronous screen multiplexer: tracks the game phase and forwards one draw
// stage to the VGA output, switching only at the start of vertical blanking.
module screen_select
  import vga_pkg::*;
#(
  parameter int unsigned WIN_FRAMES   = 300,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic    clk,
  input  logic    rst,
  vga_if.in       menu_in,
  vga_if.in       game_in,
  vga_if.in       p1_in,
  vga_if.in       p2_in,
  input  logic    start,
  input  logic    p1_win,
  input  logic    p2_win,
  vga_if.out      vga_out,
  output screen_t screen
);

  localparam logic [FRAME_W-1:0] WIN_LAST   = FRAME_W'(WIN_FRAMES - 1);
  localparam bit                 BLINK_EN   = (BLINK_FRAMES != 0);
  localparam logic [FRAME_W-1:0] BLINK_LAST = BLINK_EN ? FRAME_W'(BLINK_FRAMES - 1) : '0;

  screen_t            state_q, state_d;
  screen_t            pend_st_q, pend_st_d;
  logic               pend_vld_q, pend_vld_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRAME_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  vga_t               out_q, out_d;
  vga_t               menu_s, game_s, p1_s, p2_s, sel;
  logic               tick;

  frame_tick u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (game_in.vblnk),
    .tick  (tick)
  );

  assign menu_s = {menu_in.vcount, menu_in.hcount, menu_in.vsync, menu_in.hsync,
                   menu_in.vblnk, menu_in.hblnk, menu_in.rgb};
  assign game_s = {game_in.vcount, game_in.hcount, game_in.vsync, game_in.hsync,
                   game_in.vblnk, game_in.hblnk, game_in.rgb};
  assign p1_s   = {p1_in.vcount, p1_in.hcount, p1_in.vsync, p1_in.hsync,
                   p1_in.vblnk, p1_in.hblnk, p1_in.rgb};
  assign p2_s   = {p2_in.vcount, p2_in.hcount, p2_in.vsync, p2_in.hsync,
                   p2_in.vblnk, p2_in.hblnk, p2_in.rgb};

  // Phase tracking: events become a pending request that is applied on the next frame tick.
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_st_d   = pend_st_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    if (tick) begin
      pend_vld_d = 1'b0;
      pend_st_d  = MENU;
      if (pend_vld_q) begin
        state_d = pend_st_q;
      end else if (is_won(state_q) && (frame_cnt_q == WIN_LAST)) begin
        state_d = MENU;
      end

      if (state_d != state_q) begin
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b1;
      end else if (is_won(state_q)) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        if (BLINK_EN) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + FRAME_W'(1);
          end
        end
      end else begin
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b1;
      end
    end

    // Legality is judged against the phase that will hold after this cycle, so an
    // event on a tick cycle queues for the following tick.
    unique case (state_d)
      MENU: begin
        if (start) begin
          pend_vld_d = 1'b1;
          pend_st_d  = GAME;
        end
      end
      GAME: begin
        if (!pend_vld_d) begin
          if (p1_win) begin
            pend_vld_d = 1'b1;
            pend_st_d  = P1_WON;
          end else if (p2_win) begin
            pend_vld_d = 1'b1;
            pend_st_d  = P2_WON;
          end
        end
      end
      P1_WON, P2_WON: begin
        if (start) begin
          pend_vld_d = 1'b1;
          pend_st_d  = MENU;
        end
      end
      default: ;
    endcase
  end

  // Source select with winner-screen blanking of rgb only.
  always_comb begin
    sel = menu_s;
    unique case (state_q)
      MENU:    sel = menu_s;
      GAME:    sel = game_s;
      P1_WON:  sel = p1_s;
      P2_WON:  sel = p2_s;
      default: sel = menu_s;
    endcase
    out_d = sel;
    if (is_won(state_q) && !blink_q) begin
      out_d.rgb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MENU;
      pend_vld_q  <= 1'b0;
      pend_st_q   <= MENU;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_st_q   <= pend_st_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      out_q       <= out_d;
    end
  end

  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.rgb    = out_q.rgb;
  assign screen         = state_q;

endmodule

// File: tb/tb_screen_select.sv
// Scoreboard bench for screen_select on a small synthetic 16x10 raster.
module tb_screen_select;
  import vga_pkg::*;

  localparam int unsigned WIN   = 3;
  localparam int unsigned BLINK = 1;
  localparam int H_TOT = 16;
  localparam int V_TOT = 10;

  typedef struct packed {
    vga_t    v;
    screen_t scr;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst, start, p1_win, p2_win;
  screen_t screen;
  vga_t    menu_v, game_v, p1_v, p2_v, out_v;

  vga_if menu_if ();
  vga_if game_if ();
  vga_if p1_if ();
  vga_if p2_if ();
  vga_if out_if ();

  assign {menu_if.vcount, menu_if.hcount, menu_if.vsync, menu_if.hsync,
          menu_if.vblnk, menu_if.hblnk, menu_if.rgb} = menu_v;
  assign {game_if.vcount, game_if.hcount, game_if.vsync, game_if.hsync,
          game_if.vblnk, game_if.hblnk, game_if.rgb} = game_v;
  assign {p1_if.vcount, p1_if.hcount, p1_if.vsync, p1_if.hsync,
          p1_if.vblnk, p1_if.hblnk, p1_if.rgb} = p1_v;
  assign {p2_if.vcount, p2_if.hcount, p2_if.vsync, p2_if.hsync,
          p2_if.vblnk, p2_if.hblnk, p2_if.rgb} = p2_v;
  assign out_v = {out_if.vcount, out_if.hcount, out_if.vsync, out_if.hsync,
                  out_if.vblnk, out_if.hblnk, out_if.rgb};

  always #5 clk = ~clk;

  screen_select #(.WIN_FRAMES(WIN), .BLINK_FRAMES(BLINK)) dut (
    .clk     (clk),
    .rst     (rst),
    .menu_in (menu_if),
    .game_in (game_if),
    .p1_in   (p1_if),
    .p2_in   (p2_if),
    .start   (start),
    .p1_win  (p1_win),
    .p2_win  (p2_win),
    .vga_out (out_if),
    .screen  (screen)
  );

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   hc = 0;
  int   vc = 0;

  // Hand-stated expectation for the screen after the next vblnk rise.
  screen_t nxt_scr = MENU;
  logic    nxt_dark = 1'b0;
  int      req_n = 0;

  function automatic vga_t mk(input logic [3:0] tag);
    vga_t v;
    v.hcount = CNT_W'(hc);
    v.vcount = CNT_W'(vc);
    v.hblnk  = (hc >= 12);
    v.hsync  = (hc == 13) || (hc == 14);
    v.vblnk  = (vc >= 8);
    v.vsync  = (vc == 8);
    v.rgb    = {tag, 4'(vc), 4'(hc)};
    return v;
  endfunction

  task automatic upd();
    menu_v = mk(4'h1);
    game_v = mk(4'h2);
    p1_v   = mk(4'h3);
    p2_v   = mk(4'h4);
  endtask

  task automatic cyc(input logic s = 1'b0, input logic w1 = 1'b0,
                     input logic w2 = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    if (hc == H_TOT - 1) begin
      hc = 0;
      vc = (vc == V_TOT - 1) ? 0 : vc + 1;
    end else begin
      hc = hc + 1;
    end
    upd();
    start  = s;
    p1_win = w1;
    p2_win = w2;
    rst    = r;
  endtask

  // Runs up to and just past the cycle whose inputs carry a vblnk rise.
  task automatic run_to_tick();
    int   n;
    logic pv;
    n = 0;
    do begin
      pv = game_v.vblnk;
      cyc();
      n++;
    end while (!(game_v.vblnk && !pv) && n < 400);
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL tick_wait got=no_vblnk_rise exp=rise_within_400");
    end
    cyc();
  endtask

  task automatic expect_next(input screen_t s, input logic d);
    nxt_scr  = s;
    nxt_dark = d;
    req_n++;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Expected-output producer: one entry per clock edge.
  screen_t cur_scr = MENU;
  logic    cur_dark = 1'b0;
  logic    prev_vb = 1'b0;
  int      done_n = 0;

  always @(posedge clk) begin : pusher
    exp_t e;
    logic tk;
    e  = '0;
    tk = game_v.vblnk && !prev_vb;
    if (rst) begin
      cur_scr  = MENU;
      cur_dark = 1'b0;
      prev_vb  = 1'b0;
      done_n   = req_n;
    end else begin
      case (cur_scr)
        MENU:    e.v = menu_v;
        GAME:    e.v = game_v;
        P1_WON:  e.v = p1_v;
        default: e.v = p2_v;
      endcase
      if (cur_dark) e.v.rgb = '0;
      if (tk && (req_n != done_n)) begin
        cur_scr  = nxt_scr;
        cur_dark = nxt_dark;
        done_n   = req_n;
      end
      e.scr   = cur_scr;
      prev_vb = game_v.vblnk;
    end
    q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t a;
    #1;
    if (q.size() > 0) begin
      e     = q.pop_front();
      a.v   = out_v;
      a.scr = screen;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL out_cmp t=%0t got scr=%0d v=%h exp scr=%0d v=%h",
                 $time, a.scr, a.v, e.scr, e.v);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; p1_win = 1'b0; p2_win = 1'b0;
    upd();
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Menu for two frames; a win pulse in MENU has no effect.
    repeat (20) cyc();
    cyc(1'b0, 1'b1, 1'b0);
    run_to_tick();
    run_to_tick();
    chk("screen_menu", 16'(screen), 16'(MENU));

    // Start mid-frame: game appears only once blanking has begun.
    repeat (50) cyc();
    cyc(1'b1);
    expect_next(GAME, 1'b0);
    run_to_tick();
    cyc();
    chk("first_game_tag", 16'(out_v.rgb[11:8]), 16'h2);
    chk("first_game_vblnk", 16'(out_v.vblnk), 16'h1);

    // Simultaneous wins favour player 1; a later p2 pulse is ignored.
    repeat (30) cyc();
    cyc(1'b0, 1'b1, 1'b1);
    repeat (5) cyc();
    cyc(1'b0, 1'b0, 1'b1);
    expect_next(P1_WON, 1'b0);
    run_to_tick();
    chk("screen_p1", 16'(screen), 16'(P1_WON));
    expect_next(P1_WON, 1'b1);
    run_to_tick();
    chk("p1_frame_cnt", dut.frame_cnt_q, 16'd1);

    // Start at won frame 1 returns to menu on the next tick.
    repeat (30) cyc();
    cyc(1'b1);
    expect_next(MENU, 1'b0);
    run_to_tick();
    chk("menu_frame_cnt", dut.frame_cnt_q, 16'd0);
    chk("screen_menu2", 16'(screen), 16'(MENU));

    // Player 2 win: blink per frame and timeout on the third tick.
    repeat (40) cyc();
    cyc(1'b1);
    expect_next(GAME, 1'b0);
    run_to_tick();
    repeat (20) cyc();
    cyc(1'b1);
    repeat (10) cyc();
    cyc(1'b0, 1'b0, 1'b1);
    expect_next(P2_WON, 1'b0);
    run_to_tick();
    expect_next(P2_WON, 1'b1);
    run_to_tick();
    expect_next(P2_WON, 1'b0);
    run_to_tick();
    chk("p2_frame_cnt", dut.frame_cnt_q, 16'd2);
    expect_next(MENU, 1'b0);
    run_to_tick();
    chk("timeout_screen", 16'(screen), 16'(MENU));
    chk("timeout_frame_cnt", dut.frame_cnt_q, 16'd0);

    // Reset while game pixels are active.
    repeat (10) cyc();
    cyc(1'b1);
    expect_next(GAME, 1'b0);
    run_to_tick();
    repeat (80) cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("rst_out_rgb", 16'(out_v.rgb), 16'h0);
    chk("rst_out_cnt", 16'(out_v.hcount), 16'h0);
    cyc();
    chk("rst_screen", 16'(screen), 16'(MENU));
    chk("rst_menu_tag", 16'(out_v.rgb[11:8]), 16'h1);
    run_to_tick();
    repeat (20) cyc();

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
